// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> RESP, one access per two cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with a fairness window.
module dmem_arbiter #(
  parameter int unsigned MEM_SIZE_KB = 1,
  parameter int unsigned FAIR_WIN    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [2:0]  i_funct3_0,
  input  logic [2:0]  i_funct3_1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_gnt0,
  output logic        o_gnt1,
  output logic        o_done0,
  output logic        o_done1,
  output logic        o_err0,
  output logic        o_err1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic [31:0] o_memAddr,
  output logic [2:0]  o_memFunct3,
  output logic [31:0] o_memDataOut,
  input  logic [31:0] i_memDataIn,
  output logic        o_busy
);

  localparam logic [32:0] MemBytes = 33'(MEM_SIZE_KB) << 10;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        arb_ok;
  logic        win1;
  logic        we_q, we_d;
  logic        port_q, port_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        illegal;

  // Arbitration happens on edges leaving IDLE or RESP with something pending.
  assign arb_ok = (state_q != StAccess) && (i_req0 || i_req1);

`ifdef DMEM_ARB_RR_EN
  logic ptr_q, ptr_d;  // 1: port 1 wins the next conflict

  always_comb begin
    win1  = i_req1 && (!i_req0 || ptr_q);
    ptr_d = ptr_q;
    if (arb_ok) ptr_d = !win1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  localparam int unsigned CntW = ($clog2(FAIR_WIN + 1) > 0) ? $clog2(FAIR_WIN + 1) : 1;
  localparam logic [CntW-1:0] FairMax = CntW'(FAIR_WIN);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    win1  = i_req1 && (!i_req0 || (cnt_q >= FairMax));
    cnt_d = cnt_q;
    if (!i_req1)     cnt_d = '0;
    else if (arb_ok) cnt_d = win1 ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = arb_ok ? StAccess : StIdle;
      StAccess: state_d = StResp;
      StResp:   state_d = arb_ok ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    unique case (f3_q)
      3'd0, 3'd4: illegal = 1'b0;
      3'd1, 3'd5: illegal = addr_q[0];
      3'd2:       illegal = (addr_q[1:0] != 2'b00);
      default:    illegal = 1'b1;
    endcase
    if ({1'b0, addr_q} >= MemBytes) illegal = 1'b1;
  end

  // Request latch and response registers
  always_comb begin
    we_d     = we_q;
    port_d   = port_q;
    addr_d   = addr_q;
    f3_d     = f3_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (arb_ok) begin
      port_d  = win1;
      we_d    = win1 ? i_we1 : i_we0;
      addr_d  = win1 ? i_addr1 : i_addr0;
      f3_d    = win1 ? i_funct3_1 : i_funct3_0;
      wdata_d = win1 ? i_wdata1 : i_wdata0;
    end
    if (state_q == StAccess) begin
      err_d = illegal;
      if (!illegal && !we_q) begin
        if (port_q) rdata1_d = i_memDataIn;
        else        rdata0_d = i_memDataIn;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      addr_q   <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      we_q     <= we_d;
      port_q   <= port_d;
      addr_q   <= addr_d;
      f3_q     <= f3_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Output logic
  always_comb begin
    o_gnt0     = (state_q == StAccess) && !port_q;
    o_gnt1     = (state_q == StAccess) && port_q;
    o_done0    = (state_q == StResp) && !port_q;
    o_done1    = (state_q == StResp) && port_q;
    o_err0     = o_done0 && err_q;
    o_err1     = o_done1 && err_q;
    o_memRead  = (state_q == StAccess) && !illegal && !we_q;
    o_memWrite = (state_q == StAccess) && !illegal && we_q;
    o_busy     = (state_q != StIdle);
  end

  assign o_memAddr    = addr_q;
  assign o_memFunct3  = f3_q;
  assign o_memDataOut = wdata_q;
  assign o_rdata0     = rdata0_q;
  assign o_rdata1     = rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MEM_SIZE_KB, default 1: data memory size in KB, used for the address range check.
REQ-002 SHALL have parameter FAIR_WIN, default 4: count of consecutive port-0 grants after which a waiting port 1 is forced through (fixed-priority mode only).
REQ-003 SHALL have port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports i_req0 / i_req1, input, 1: access request from port 0 (core LSU) / port 1 (debug/DMA).
REQ-006 SHALL have ports i_we0 / i_we1, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have ports i_addr0 / i_addr1, input, 32: byte address.
REQ-008 SHALL have ports i_funct3_0 / i_funct3_1, input, 3: RISC-V load/store size code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-009 SHALL have ports i_wdata0 / i_wdata1, input, 32: store data.
REQ-010 SHALL have ports o_gnt0 / o_gnt1, output, 1: one-cycle grant pulse; request fields captured.
REQ-011 SHALL have ports o_done0 / o_done1, output, 1: one-cycle completion pulse.
REQ-012 SHALL have ports o_err0 / o_err1, output, 1: error flag, valid with done.
REQ-013 SHALL have ports o_rdata0 / o_rdata1, output, 32: load data, valid with done; held until that port's next done.
REQ-014 SHALL have ports o_memRead / o_memWrite, output, 1: dmem read/write enables.
REQ-015 SHALL have ports o_memAddr (output, 32), o_memFunct3 (output, 3) and o_memDataOut (output, 32), driven to dmem.
REQ-016 SHALL have port i_memDataIn, input, 32: dmem combinational read data.
REQ-017 SHALL have port o_busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-019 IDLE or RESP, any request pending: SHALL latch the winner's we/addr/funct3/wdata at the clock edge, enter ACCESS, and assert o_gntN for exactly that ACCESS cycle.
REQ-020 IDLE, no request pending: SHALL remain in IDLE. RESP, no request pending: SHALL go to IDLE.
REQ-021 Requesters SHALL hold req and fields stable until they sample gnt; the arbiter SHALL ignore field changes after capture.
REQ-022 ACCESS: SHALL drive o_memAddr, o_memFunct3 and o_memDataOut from the latch; o_memWrite = we and o_memRead = !we, each gated by a legal access.
REQ-023 Store SHALL commit in dmem at the edge ending ACCESS; load SHALL register i_memDataIn into o_rdataN at that edge.
REQ-024 RESP: SHALL pulse o_doneN for the granted port only.
REQ-025 Latency SHALL be grant at edge+1 and done at edge+2 after a request is sampled; sustained throughput SHALL be one access per 2 cycles.
REQ-026 Illegal access SHALL be: H/HU with addr[0]=1, W with addr[1:0]!=0, funct3 in {3,6,7}, or addr >= MEM_SIZE_KB*1024.
REQ-027 Illegal access SHALL keep memRead and memWrite at 0 in ACCESS, leave o_rdataN unchanged, and give o_errN=1 with o_doneN in RESP.
REQ-028 Outside ACCESS, o_memRead and o_memWrite SHALL be 0; o_memAddr, o_memFunct3 and o_memDataOut SHALL hold their last values.
REQ-029 Both ports requesting SHALL be resolved per the Configuration section; o_gnt0 and o_gnt1 SHALL never both be high.

Reset
REQ-030 i_rst high SHALL immediately force IDLE and clear the latch, all gnt/done/err/rdata outputs, memRead, memWrite, memAddr, memFunct3, memDataOut, o_busy, the priority pointer and the fairness counter to 0.
REQ-031 Reset during ACCESS SHALL abort the access: no store commit and no done pulse.
REQ-032 First grant after reset release SHALL occur at the first edge at which a request is sampled.

Configuration
REQ-033 DMEM_ARB_RR_EN defined: SHALL use round-robin; on conflict the port not granted last wins, and the pointer resets to favour port 0.
REQ-034 DMEM_ARB_RR_EN undefined: SHALL use fixed priority to port 0, except that after FAIR_WIN consecutive port-0 grants while port 1 is waiting, port 1 SHALL win once; the counter clears on any port-1 grant or when port 1 is idle.

Verification
REQ-035 Port 0 stores W 10 to 0x8, then loads 0x8 -> gnt0 one cycle after req, done0 two cycles after req, o_rdata0 = 10, err0 = 0.
REQ-036 Port 1 stores W 102 to 0xC while port 0 idles -> memWrite high for exactly one cycle, addr 0xC; port 0 load of 0xC returns 102.
REQ-037 Port 0 W store to 0x33242344 and H load at 0x101 -> err0 = 1 both times, memWrite and memRead never high, o_rdata0 unchanged.
REQ-038 Both ports request continuously for 12 cycles -> RR build: grants alternate 0,1,0,1... every 2 cycles; fixed build with FAIR_WIN=4: 0,0,0,0,1 repeating.
REQ-039 Assert i_rst in the ACCESS cycle of a port-1 store of 443 to 0x100 -> no done1, a following load of 0x100 returns its prior value, and all outputs read 0 during reset.
